// File: rtl/atomrvcore_ifu.sv
// rtl/atomrvcore_ifu.sv - instruction fetch unit: PC, credited imem requests, tagged instruction buffer, redirect flush
module atomrvcore_ifu #(
  parameter int                   DATAWIDTH  = 32,
  parameter logic [DATAWIDTH-1:0] RESET_PC   = '0,
  parameter int                   FIFO_DEPTH = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  output logic                 imem_req_o,
  output logic [DATAWIDTH-1:0] imem_addr_o,
  input  logic                 imem_gnt_i,
  input  logic                 imem_rvalid_i,
  input  logic [DATAWIDTH-1:0] imem_rdata_i,
  output logic [DATAWIDTH-1:0] instr_o,
  output logic [DATAWIDTH-1:0] instr_pc_o,
  output logic                 instr_valid_o,
  input  logic                 instr_ready_i,
  input  logic                 BE_i,
  input  logic                 UJE_i,
  input  logic                 JALRE_i,
  input  logic [DATAWIDTH-1:0] immed_i,
  input  logic [DATAWIDTH-1:0] operand_A_i,
  input  logic [DATAWIDTH-1:0] redirect_pc_i
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

  logic [DATAWIDTH-1:0] pc_q;
  logic [CW-1:0]        outstanding_q, discard_q, count_q, outstanding_nxt;
  logic [PW-1:0]        buf_wr_q, buf_rd_q, tag_wr_q, tag_rd_q;
  logic [DATAWIDTH-1:0] buf_instr [FIFO_DEPTH];
  logic [DATAWIDTH-1:0] buf_pc    [FIFO_DEPTH];
  logic [DATAWIDTH-1:0] tag_pc    [FIFO_DEPTH];

  logic                 redirect, fire_req, keep_rsp, pop;
  logic [DATAWIDTH-1:0] target;
  logic [CW:0]          inflight;

  always_comb begin
    redirect = BE_i | UJE_i | JALRE_i;
    if (JALRE_i)
      target = (operand_A_i + immed_i) & ~{{(DATAWIDTH-1){1'b0}}, 1'b1};
    else
      target = redirect_pc_i + (immed_i << 1);

    // Every issued request owns a buffer slot, so a granted word can always be stored.
    inflight   = {1'b0, outstanding_q} + {1'b0, count_q};
    imem_req_o = rst_ni & ~redirect & (inflight < DEPTH_C);
    fire_req   = imem_req_o & imem_gnt_i;
    keep_rsp   = imem_rvalid_i & (discard_q == '0) & ~redirect;

    instr_valid_o = (count_q != '0);
    pop           = instr_valid_o & instr_ready_i;
    instr_o       = instr_valid_o ? buf_instr[buf_rd_q] : '0;
    instr_pc_o    = instr_valid_o ? buf_pc[buf_rd_q]    : '0;
    imem_addr_o   = pc_q;

    outstanding_nxt = outstanding_q + CW'(fire_req) - CW'(imem_rvalid_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q          <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
      count_q       <= '0;
      buf_wr_q      <= '0;
      buf_rd_q      <= '0;
      tag_wr_q      <= '0;
      tag_rd_q      <= '0;
    end else begin
      outstanding_q <= outstanding_nxt;
      if (redirect) begin
        // Everything still in flight is wrong-path; the tag queue is emptied so
        // those responses are dropped without touching it.
        pc_q      <= target;
        discard_q <= outstanding_nxt;
        count_q   <= '0;
        buf_wr_q  <= '0;
        buf_rd_q  <= '0;
        tag_rd_q  <= tag_wr_q;
      end else begin
        if (fire_req) begin
          pc_q     <= pc_q + DATAWIDTH'(4);
          tag_wr_q <= tag_wr_q + PW'(1);
        end
        if (imem_rvalid_i && discard_q != '0)
          discard_q <= discard_q - CW'(1);
        if (keep_rsp) begin
          buf_wr_q <= buf_wr_q + PW'(1);
          tag_rd_q <= tag_rd_q + PW'(1);
        end
        if (pop)
          buf_rd_q <= buf_rd_q + PW'(1);
        count_q <= count_q + CW'(keep_rsp) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (fire_req)
      tag_pc[tag_wr_q] <= pc_q;
    if (keep_rsp) begin
      buf_instr[buf_wr_q] <= imem_rdata_i;
      buf_pc[buf_wr_q]    <= tag_pc[tag_rd_q];
    end
  end

  rvalid_has_owner: assert property (@(posedge clk_i) disable iff (!rst_ni)
    imem_rvalid_i |-> (outstanding_q != '0));

endmodule

// File: tb/tb_atomrvcore_ifu.sv
// tb/tb_atomrvcore_ifu.sv - randomized bench for atomrvcore_ifu against a queue-level fetch model
module tb_atomrvcore_ifu;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk, rst_n;
  logic        req, gnt, rvalid, valid, ready;
  logic [31:0] addr, rdata, instr, instr_pc;
  logic        be, uje, jalre;
  logic [31:0] immed, operand_a, redirect_pc;

  atomrvcore_ifu #(.DATAWIDTH(32), .RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .imem_req_o(req), .imem_addr_o(addr), .imem_gnt_i(gnt),
    .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
    .instr_o(instr), .instr_pc_o(instr_pc), .instr_valid_o(valid), .instr_ready_i(ready),
    .BE_i(be), .UJE_i(uje), .JALRE_i(jalre),
    .immed_i(immed), .operand_A_i(operand_a), .redirect_pc_i(redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a * 32'd2654435761) ^ 32'h5A5A_1234;
  endfunction

  // Reference model: memory-side pending requests and decode-visible buffer as queues.
  logic [31:0] aq[$];
  int          dq[$];
  logic [31:0] bq[$];
  int          stale = 0;
  logic [31:0] fetch_pc = RESET_PC;
  int          cyc = 0;
  int          delivered = 0;

  task automatic clear_inputs();
    gnt = 0; rvalid = 0; rdata = 0; ready = 0;
    be = 0; uje = 0; jalre = 0; immed = 0; operand_a = 0; redirect_pc = 0;
  endtask

  task automatic drive_random();
    clear_inputs();
    gnt   = ($urandom_range(0, 3) != 0);
    ready = ($urandom_range(0, 3) != 0);
    if (aq.size() > 0 && dq[0] <= cyc && $urandom_range(0, 3) != 0) begin
      rvalid = 1;
      rdata  = word_of(aq[0]);
    end else begin
      rdata = $urandom();
    end
    if ($urandom_range(0, 11) == 0) begin
      be    = 1'($urandom_range(0, 1));
      uje   = 1'($urandom_range(0, 1));
      jalre = 1'($urandom_range(0, 1));
      if (!(be | uje | jalre)) be = 1;
      immed       = 32'($urandom_range(0, 127)) - 32'd64;
      operand_a   = $urandom();
      redirect_pc = $urandom() & 32'hFFFF_FFFC;
    end
  endtask

  task automatic do_cycle();
    bit          redir, exp_req, keep, pop;
    logic [31:0] tgt, a;
    #1;
    redir   = be | uje | jalre;
    exp_req = !redir && (aq.size() + bq.size() < DEPTH);
    if (jalre) tgt = (operand_a + immed) & 32'hFFFF_FFFE;
    else       tgt = redirect_pc + immed * 2;

    check_eq("req", 32'(req), 32'(exp_req));
    if (exp_req) check_eq("addr", addr, fetch_pc);
    check_eq("valid", 32'(valid), 32'(bq.size() != 0));
    if (bq.size() != 0) begin
      check_eq("instr_pc", instr_pc, bq[0]);
      check_eq("instr", instr, word_of(bq[0]));
    end

    keep = 0;
    a    = '0;
    if (rvalid) begin
      a = aq.pop_front();
      void'(dq.pop_front());
      if (stale > 0) stale--;
      else keep = !redir;
    end
    pop = (bq.size() != 0) && ready;
    if (pop) begin
      void'(bq.pop_front());
      delivered++;
    end
    if (redir) begin
      bq.delete();
      stale    = aq.size();
      fetch_pc = tgt;
    end else begin
      if (keep) bq.push_back(a);
      if (exp_req && gnt) begin
        aq.push_back(fetch_pc);
        dq.push_back(cyc + 1 + int'($urandom_range(0, 2)));
        fetch_pc = fetch_pc + 32'd4;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 0;
    clear_inputs();
    @(negedge clk);
    @(negedge clk);
    #1;
    check_eq("rst_req", 32'(req), 0);
    check_eq("rst_valid", 32'(valid), 0);
    check_eq("rst_addr", addr, RESET_PC);
    check_eq("rst_instr", instr, 0);
    check_eq("rst_pc", instr_pc, 0);
    @(negedge clk);
    rst_n = 1;

    for (int i = 0; i < 1200; i++) begin
      drive_random();
      if (i < 40) begin
        // Clean streaming start: always granted and ready, no redirects.
        be = 0; uje = 0; jalre = 0; gnt = 1; ready = 1;
      end
      if (i == 100) begin
        be = 1; uje = 0; jalre = 0; redirect_pc = 32'h10; immed = 32'h8;
      end
      if (i == 150) begin
        be = 0; uje = 0; jalre = 1; operand_a = 32'h101; immed = 32'h4;
      end
      if (i == 250) begin
        be = 0; uje = 1; jalre = 0; redirect_pc = 32'hFFFF_FFF0; immed = 32'h4;
      end
      if (i >= 300 && i < 400 && rvalid && bq.size() > 0) begin
        be = 1; uje = 0; jalre = 0; ready = 1;
        redirect_pc = $urandom() & 32'hFFFF_FFFC; immed = 32'h20;
      end
      if (i >= 500 && i < 512) begin
        ready = 0; be = 0; uje = 0; jalre = 0;
      end

      if (i == 700) begin
        clear_inputs();
        rst_n = 0;
        #1;
        check_eq("midrst_req", 32'(req), 0);
        check_eq("midrst_valid", 32'(valid), 0);
        check_eq("midrst_instr", instr, 0);
        check_eq("midrst_addr", addr, RESET_PC);
        aq.delete(); dq.delete(); bq.delete();
        stale    = 0;
        fetch_pc = RESET_PC;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        #1;
        check_eq("midrst_first_addr", addr, RESET_PC);
        check_eq("midrst_first_req", 32'(req), 1);
        @(negedge clk);
        continue;
      end

      do_cycle();

      if (i == 100) check_eq("be_tgt", addr, 32'h20);
      if (i == 150) check_eq("jalr_tgt", addr, 32'h104);
      if (i == 250) check_eq("wrap_tgt", addr, 32'hFFFF_FFF8);
      if (i == 511) check_eq("stall_req", 32'(req), 0);
    end

    check_eq("progress", 32'(delivered > 100), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
